// File: rtl/mb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mb_bus_arbiter
//   Decides who owns the 68000/motherboard bus: the CPU, a motherboard DMA
//   master using the BR/BG/BGACK 3-wire protocol, or the on-card local
//   requester using LREQ/LGNT. The arbiter first takes the bus from the CPU
//   with the BR/BG handshake. It then waits for the bus to be idle for
//   SETTLE_CYCLES consecutive cycles, grants exactly one requester, and
//   returns the bus to the CPU through a single RELEASE cycle.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a motherboard grant that is never acknowledged with
//     BGACK_MB_n is withdrawn after TIMEOUT_CYCLES cycles, and TIMEOUT pulses.
//     When undefined, GRANT_MB waits indefinitely and TIMEOUT is tied to 0.
//
// Request/grant semantics
//   LREQ is a level signal. LGNT rises once the local requester owns the bus.
//   Dropping LREQ releases the bus, so the requester must complete its own
//   cycle before dropping LREQ. A motherboard master owns the bus from the
//   moment it asserts BGACK_MB_n while BG_MB_n is low, until it negates
//   BGACK_MB_n.
//
// Ports
//   C7M         in   bus clock, all state changes on its rising edge
//   RESET       in   asynchronous active-high reset
//   AS_CPU_n    in   CPU address strobe
//   DTACK_n     in   combined data transfer acknowledge
//   HALT_n      in   0 blocks new arbitration (an ongoing tenure is unaffected)
//   BR_MB_n     in   motherboard bus request
//   BGACK_MB_n  in   motherboard bus grant acknowledge
//   BG_CPU_n    in   bus grant from the CPU
//   LREQ        in   local request (level)
//   BR_CPU_n    out  bus request to the CPU
//   BG_MB_n     out  bus grant to the motherboard masters
//   BGACK_L_n   out  bus grant acknowledge while the local requester owns the bus
//   LGNT        out  local grant
//   LPREEMPT    out  local owns the bus and a motherboard master is requesting
//   BUS_OE      out  1 = CPU side drives AS_MB_n, 0 = tristate
//   OWNER       out  00 CPU, 01 MB, 10 local, 11 handover
//   TIMEOUT     out  one-cycle pulse when an unacknowledged MB grant is dropped
// -----------------------------------------------------------------------------
module mb_bus_arbiter #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       DTACK_n,
  input  logic       HALT_n,
  input  logic       BR_MB_n,
  input  logic       BGACK_MB_n,
  input  logic       BG_CPU_n,
  input  logic       LREQ,
  output logic       BR_CPU_n,
  output logic       BG_MB_n,
  output logic       BGACK_L_n,
  output logic       LGNT,
  output logic       LPREEMPT,
  output logic       BUS_OE,
  output logic [1:0] OWNER,
  output logic       TIMEOUT
);

  // The timeout counter is 7 bits wide.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..127");
  end

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] OWN_CPU = 2'b00;
  localparam logic [1:0] OWN_MB  = 2'b01;
  localparam logic [1:0] OWN_LOC = 2'b10;
  localparam logic [1:0] OWN_HO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_END,
    S_GRANT_MB,
    S_OWN_MB,
    S_OWN_L,
    S_RELEASE
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   settle_cnt, settle_nx, settle_inc;
  logic            last_local, last_local_nx;   // 0 = MB owned last, 1 = local
  logic            br_nx, bg_nx, bgack_l_nx, lgnt_nx, oe_nx;
  logic [1:0]      owner_nx;
  logic            bus_idle, mb_pend;

`ifdef ARB_TIMEOUT_EN
  logic [6:0]      tcnt, tcnt_nx, tcnt_inc;
  logic            tout_nx;
`endif

  // The bus may be handed over only when no CPU cycle is in flight and no
  // motherboard master still holds BGACK.
  assign bus_idle   = AS_CPU_n & DTACK_n & BGACK_MB_n;
  assign mb_pend    = ~BR_MB_n;
  assign settle_inc = settle_cnt + SW'(1);

`ifdef ARB_TIMEOUT_EN
  assign tcnt_inc = tcnt + 7'd1;
`endif

  always_comb begin
    state_nx      = state;
    settle_nx     = settle_cnt;
    last_local_nx = last_local;
    br_nx         = BR_CPU_n;
    bg_nx         = BG_MB_n;
    bgack_l_nx    = BGACK_L_n;
    lgnt_nx       = LGNT;
    oe_nx         = BUS_OE;
    owner_nx      = OWNER;
`ifdef ARB_TIMEOUT_EN
    tout_nx       = 1'b0;
    tcnt_nx       = (state == S_GRANT_MB) ? tcnt_inc : 7'd0;
`endif

    case (state)
      S_IDLE: begin
        settle_nx = '0;
        if (HALT_n && (mb_pend || LREQ)) begin
          state_nx = S_REQ;
          br_nx    = 1'b0;
        end
      end

      S_REQ: begin
        if (!BG_CPU_n) begin
          state_nx  = S_WAIT_END;
          owner_nx  = OWN_HO;
          settle_nx = '0;
        end
      end

      S_WAIT_END: begin
        if (!bus_idle) begin
          settle_nx = '0;
        end else if (settle_inc == SW'(SETTLE_CYCLES)) begin
          settle_nx = '0;
          oe_nx     = 1'b0;
          // On a tie, the requester that did not own the bus last wins.
          if (mb_pend && (!LREQ || last_local)) begin
            state_nx = S_GRANT_MB;
            bg_nx    = 1'b0;
          end else if (LREQ) begin
            state_nx   = S_OWN_L;
            lgnt_nx    = 1'b1;
            bgack_l_nx = 1'b0;
            owner_nx   = OWN_LOC;
          end else begin
            state_nx = S_RELEASE;
          end
        end else begin
          settle_nx = settle_inc;
        end
      end

      S_GRANT_MB: begin
        if (!BGACK_MB_n) begin
          state_nx = S_OWN_MB;
          bg_nx    = 1'b1;
          owner_nx = OWN_MB;
        end else if (BR_MB_n) begin
          state_nx = S_RELEASE;
          bg_nx    = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt_inc == 7'(TIMEOUT_CYCLES)) begin
          state_nx      = S_RELEASE;
          bg_nx         = 1'b1;
          tout_nx       = 1'b1;
          last_local_nx = 1'b0;
        end
`endif
      end

      S_OWN_MB: begin
        if (BGACK_MB_n) begin
          state_nx      = S_RELEASE;
          owner_nx      = OWN_HO;
          last_local_nx = 1'b0;
        end
      end

      S_OWN_L: begin
        if (!LREQ) begin
          state_nx      = S_RELEASE;
          lgnt_nx       = 1'b0;
          bgack_l_nx    = 1'b1;
          owner_nx      = OWN_HO;
          last_local_nx = 1'b1;
        end
      end

      S_RELEASE: begin
        state_nx = S_IDLE;
        br_nx    = 1'b1;
        bg_nx    = 1'b1;
        oe_nx    = 1'b1;
        owner_nx = OWN_CPU;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      last_local <= 1'b0;
      BR_CPU_n   <= 1'b1;
      BG_MB_n    <= 1'b1;
      BGACK_L_n  <= 1'b1;
      LGNT       <= 1'b0;
      BUS_OE     <= 1'b1;
      OWNER      <= OWN_CPU;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      last_local <= last_local_nx;
      BR_CPU_n   <= br_nx;
      BG_MB_n    <= bg_nx;
      BGACK_L_n  <= bgack_l_nx;
      LGNT       <= lgnt_nx;
      BUS_OE     <= oe_nx;
      OWNER      <= owner_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      tcnt    <= 7'd0;
      TIMEOUT <= 1'b0;
    end else begin
      tcnt    <= tcnt_nx;
      TIMEOUT <= tout_nx;
    end
  end
`else
  assign TIMEOUT = 1'b0;
`endif

  // Warns the local requester, within the same cycle, that a motherboard
  // master is waiting for the bus.
  assign LPREEMPT = (state == S_OWN_L) && !BR_MB_n;

endmodule

// File: tb/tb_mb_bus_arbiter.sv
module tb_mb_bus_arbiter;

  localparam int SETTLE = 2;
  localparam int TOUT   = 64;

  // Reference model phases (bench-local numbering)
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_GMB  = 3;
  localparam int PH_OMB  = 4;
  localparam int PH_OL   = 5;
  localparam int PH_REL  = 6;

  logic       C7M = 1'b0;
  logic       RESET;
  logic       AS_CPU_n, DTACK_n, HALT_n, BR_MB_n, BGACK_MB_n, BG_CPU_n, LREQ;
  logic       BR_CPU_n, BG_MB_n, BGACK_L_n, LGNT, LPREEMPT, BUS_OE, TIMEOUT;
  logic [1:0] OWNER;

  int checks = 0;
  int errors = 0;

  bit cpu_auto = 0;
  int cpu_lat  = 0;
  bit rand_on  = 0;

  int ph;
  int settle;
  int tcnt;
  bit last_local;
  bit tout_pulse;

  // ---------------- clock / reset ----------------
  always #5 C7M = ~C7M;

  mb_bus_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT)) dut (
    .C7M(C7M), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .DTACK_n(DTACK_n),
    .HALT_n(HALT_n), .BR_MB_n(BR_MB_n), .BGACK_MB_n(BGACK_MB_n),
    .BG_CPU_n(BG_CPU_n), .LREQ(LREQ), .BR_CPU_n(BR_CPU_n), .BG_MB_n(BG_MB_n),
    .BGACK_L_n(BGACK_L_n), .LGNT(LGNT), .LPREEMPT(LPREEMPT), .BUS_OE(BUS_OE),
    .OWNER(OWNER), .TIMEOUT(TIMEOUT)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    ph = PH_IDLE; settle = 0; tcnt = 0; last_local = 0; tout_pulse = 0;
  endtask

  task automatic model_update();
    bit bus_idle;
    bus_idle = AS_CPU_n && DTACK_n && BGACK_MB_n;
    tout_pulse = 0;
    case (ph)
      PH_IDLE: if (HALT_n && (!BR_MB_n || LREQ)) ph = PH_REQ;
      PH_REQ:  if (!BG_CPU_n) begin ph = PH_WAIT; settle = 0; end
      PH_WAIT: begin
        settle = bus_idle ? settle + 1 : 0;
        if (settle == SETTLE) begin
          settle = 0;
          tcnt = 0;
          if (!BR_MB_n && LREQ) ph = last_local ? PH_GMB : PH_OL;
          else if (!BR_MB_n)    ph = PH_GMB;
          else if (LREQ)        ph = PH_OL;
          else                  ph = PH_REL;
        end
      end
      PH_GMB: begin
        if (!BGACK_MB_n) ph = PH_OMB;
        else if (BR_MB_n) ph = PH_REL;
`ifdef ARB_TIMEOUT_EN
        else begin
          tcnt++;
          if (tcnt == TOUT) begin ph = PH_REL; tout_pulse = 1; last_local = 0; end
        end
`endif
      end
      PH_OMB: if (BGACK_MB_n) begin ph = PH_REL; last_local = 0; end
      PH_OL:  if (!LREQ) begin ph = PH_REL; last_local = 1; end
      default: ph = PH_IDLE;
    endcase
  endtask

  task automatic compare_all();
    logic [1:0] exp_owner;
    case (ph)
      PH_IDLE, PH_REQ: exp_owner = 2'b00;
      PH_OMB:          exp_owner = 2'b01;
      PH_OL:           exp_owner = 2'b10;
      default:         exp_owner = 2'b11;
    endcase
    check("br_cpu_n",  BR_CPU_n,  (ph == PH_IDLE) ? 1 : 0);
    check("bg_mb_n",   BG_MB_n,   (ph == PH_GMB) ? 0 : 1);
    check("bgack_l_n", BGACK_L_n, (ph == PH_OL) ? 0 : 1);
    check("lgnt",      LGNT,      (ph == PH_OL) ? 1 : 0);
    check("bus_oe",    BUS_OE,    (ph == PH_IDLE || ph == PH_REQ || ph == PH_WAIT) ? 1 : 0);
    check("owner",     OWNER,     exp_owner);
    check("lpreempt",  LPREEMPT,  (ph == PH_OL && !BR_MB_n) ? 1 : 0);
    check("timeout",   TIMEOUT,   tout_pulse);
    if (LGNT === 1'b1 || BG_MB_n === 1'b0) check("inv_bus_oe", BUS_OE, 0);
    if (LGNT === 1'b1) check("inv_excl", BG_MB_n, 1);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_random();
    AS_CPU_n = ($urandom_range(0, 3) != 0);
    DTACK_n  = ($urandom_range(0, 4) != 0);
    HALT_n   = ($urandom_range(0, 15) != 0);
    if (BGACK_MB_n == 1'b0) begin
      if ($urandom_range(0, 5) == 0) BGACK_MB_n = 1'b1;
    end else if (BR_MB_n == 1'b0) begin
      if (BG_MB_n == 1'b0 && $urandom_range(0, 1) == 0) begin
        BGACK_MB_n = 1'b0;
        BR_MB_n    = 1'b1;
      end else if ($urandom_range(0, 40) == 0) begin
        BR_MB_n = 1'b1;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      BR_MB_n = 1'b0;
    end
    if (LREQ) begin
      if (LGNT ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 30) == 0)) LREQ = 1'b0;
    end else if ($urandom_range(0, 7) == 0) begin
      LREQ = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge C7M);
    if (RESET) model_reset();
    else model_update();
    #1;
    compare_all();
    if (cpu_auto) begin
      if (BR_CPU_n) BG_CPU_n = 1'b1;
      else if (BG_CPU_n && $urandom_range(0, cpu_lat) == 0) BG_CPU_n = 1'b0;
    end
    if (rand_on) drive_random();
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return LGNT;
      1:       return BG_MB_n;
      2:       return BR_CPU_n;
      default: return TIMEOUT;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget,
                          input string tag, output int n);
    n = 0;
    while (get_sig(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    check(tag, get_sig(sel), val);
  endtask

  task automatic bus_quiet();
    AS_CPU_n = 1; DTACK_n = 1; HALT_n = 1; BR_MB_n = 1;
    BGACK_MB_n = 1; BG_CPU_n = 1; LREQ = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bus_quiet();
    RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    RESET = 1'b0;

    // Local only, CPU grants two cycles after the request
    LREQ = 1'b1;
    tick();
    tick();
    BG_CPU_n = 1'b0;
    wait_sig(0, 1'b1, 20, "local_grant", n);
    check("local_latency", n, 1 + SETTLE);
    check("local_bus_oe", BUS_OE, 0);
    LREQ = 1'b0;
    tick();
    check("local_release_owner", OWNER, 3);
    tick();
    check("local_idle_oe", BUS_OE, 1);
    check("local_idle_br", BR_CPU_n, 1);
    BG_CPU_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a local tenure
    LREQ = 1'b1;
    BG_CPU_n = 1'b0;
    wait_sig(0, 1'b1, 20, "rst_pre_grant", n);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check("rst_lgnt", LGNT, 0);
    check("rst_bgack_l", BGACK_L_n, 1);
    check("rst_br_cpu", BR_CPU_n, 1);
    check("rst_bus_oe", BUS_OE, 1);
    check("rst_owner", OWNER, 0);
    compare_all();
    bus_quiet();
    tick();
    RESET = 1'b0;
    tick();

    // CPU cycle in flight delays the handover
    cpu_auto = 1;
    LREQ = 1'b1;
    AS_CPU_n = 1'b0;
    repeat (4) tick();
    DTACK_n = 1'b0;
    tick();
    check("inflight_no_grant", LGNT, 0);
    AS_CPU_n = 1'b1;
    DTACK_n  = 1'b1;
    wait_sig(0, 1'b1, 20, "inflight_grant", n);
    check("inflight_settle", n, SETTLE);
    LREQ = 1'b0;
    wait_sig(2, 1'b1, 10, "inflight_release", n);

    // Motherboard 3-wire handshake
    BR_MB_n = 1'b0;
    wait_sig(1, 1'b0, 20, "mb_bg", n);
    BGACK_MB_n = 1'b0;
    BR_MB_n    = 1'b1;
    tick();
    check("mb_owner", OWNER, 1);
    check("mb_bg_off", BG_MB_n, 1);
    repeat (3) tick();
    BGACK_MB_n = 1'b1;
    wait_sig(2, 1'b1, 10, "mb_release", n);
    check("mb_idle_owner", OWNER, 0);

    // Tie after reset: local first, then MB
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    BR_MB_n = 1'b0;
    LREQ    = 1'b1;
    wait_sig(0, 1'b1, 20, "tie_local_first", n);
    check("tie_preempt", LPREEMPT, 1);
    LREQ = 1'b0;
    wait_sig(1, 1'b0, 20, "tie_mb_next", n);
    check("tie_mb_owner", OWNER, 3);
    BGACK_MB_n = 1'b0;
    BR_MB_n    = 1'b1;
    tick();
    BGACK_MB_n = 1'b1;
    wait_sig(2, 1'b1, 10, "tie_release", n);

`ifdef ARB_TIMEOUT_EN
    // Unacknowledged motherboard grant
    BR_MB_n = 1'b0;
    wait_sig(1, 1'b0, 20, "to_bg", n);
    wait_sig(3, 1'b1, TOUT + 10, "to_pulse", n);
    check("to_cycles", n, TOUT);
    check("to_bg_off", BG_MB_n, 1);
    BR_MB_n = 1'b1;
    tick();
    check("to_idle_owner", OWNER, 0);
    tick();
`endif

    // Randomized traffic checked against the model every cycle
    cpu_lat = 3;
    rand_on = 1;
    repeat (3000) tick();
    rand_on = 0;
    bus_quiet();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
